// File: rtl/internal_bus_master.sv
// rtl/internal_bus_master.sv - internal bus initiator: assigns IDs, issues requests, returns responses
module internal_bus_master #(
    parameter int IDBITS          = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_addr,
    input  logic [511:0]      cmd_data,
    input  logic              cmd_rw,
    output logic [IDBITS-1:0] cmd_id,
    output logic              mvalid,
    input  logic              mready,
    output logic [IDBITS-1:0] mid,
    output logic [31:0]       maddr,
    output logic [511:0]      mdata,
    output logic              mrw,
    input  logic              svalid,
    output logic              sready,
    input  logic [IDBITS-1:0] sid,
    input  logic [1:0]        sresp,
    input  logic [511:0]      sdata,
    input  logic              srw,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDBITS-1:0] rsp_id,
    output logic [1:0]        rsp_resp,
    output logic [511:0]      rsp_data,
    output logic              rsp_rw,
    output logic [IDBITS:0]   outstanding,
    output logic              err_unexpected
);
    localparam int              NIDS    = 1 << IDBITS;
    localparam logic [IDBITS:0] MAX_CNT = (IDBITS+1)'(MAX_OUTSTANDING);

    typedef enum logic {REQ_IDLE, REQ_ISSUE} req_state_t;

    req_state_t        state;
    req_state_t        state_next;
    logic [IDBITS-1:0] next_id;
    logic [NIDS-1:0]   inflight;
    logic [NIDS-1:0]   inflight_next;
    logic              load_req;
    logic              clear_req;
    logic              req_done;
    logic              rsp_take;
    logic              rsp_hit;
    logic              retire;
    logic              rsp_pop;

    // An ID still in flight after wrap-around must not be reissued.
    assign cmd_id    = next_id;
    assign cmd_ready = (state == REQ_IDLE) && (outstanding < MAX_CNT) && !inflight[next_id];
    assign req_done  = mvalid && mready;
    assign sready    = !rsp_valid || rsp_ready;
    assign rsp_take  = svalid && sready;
    assign rsp_hit   = inflight[sid];
    assign retire    = rsp_take && rsp_hit;
    assign rsp_pop   = rsp_valid && rsp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= REQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        clear_req  = 1'b0;
        case (state)
            REQ_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load_req   = 1'b1;
                    state_next = REQ_ISSUE;
                end
            end
            REQ_ISSUE: begin
                if (req_done) begin
                    clear_req  = 1'b1;
                    state_next = REQ_IDLE;
                end
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    // Set and clear never target the same bit: accept requires that bit to be clear.
    always_comb begin
        inflight_next = inflight;
        if (load_req) begin
            inflight_next[next_id] = 1'b1;
        end
        if (retire) begin
            inflight_next[sid] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_id     <= '0;
            inflight    <= '0;
            outstanding <= '0;
        end else begin
            inflight <= inflight_next;
            if (load_req) begin
                next_id <= next_id + 1'b1;
            end
            case ({load_req, retire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mvalid <= 1'b0;
            mid    <= '0;
            maddr  <= '0;
            mdata  <= '0;
            mrw    <= 1'b0;
        end else if (load_req) begin
            mvalid <= 1'b1;
            mid    <= next_id;
            maddr  <= cmd_addr;
            mdata  <= cmd_data;
            mrw    <= cmd_rw;
        end else if (clear_req) begin
            mvalid <= 1'b0;
        end
    end

    // Unknown IDs are still forwarded so the client sees every bus response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_resp       <= '0;
            rsp_data       <= '0;
            rsp_rw         <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (rsp_take) begin
                rsp_valid <= 1'b1;
                rsp_id    <= sid;
                rsp_resp  <= sresp;
                rsp_data  <= sdata;
                rsp_rw    <= srw;
                if (!rsp_hit) begin
                    err_unexpected <= 1'b1;
                end
            end else if (rsp_pop) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_internal_bus_master.sv
// tb/tb_internal_bus_master.sv - scoreboard bench for internal_bus_master
module tb_internal_bus_master;
    localparam int IDB = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [31:0]    cmd_addr = '0;
    logic [511:0]   cmd_data = '0;
    logic           cmd_rw = 1'b0;
    logic [IDB-1:0] cmd_id;
    logic           mvalid;
    logic           mready = 1'b0;
    logic [IDB-1:0] mid;
    logic [31:0]    maddr;
    logic [511:0]   mdata;
    logic           mrw;
    logic           svalid = 1'b0;
    logic           sready;
    logic [IDB-1:0] sid = '0;
    logic [1:0]     sresp = '0;
    logic [511:0]   sdata = '0;
    logic           srw = 1'b0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IDB-1:0] rsp_id;
    logic [1:0]     rsp_resp;
    logic [511:0]   rsp_data;
    logic           rsp_rw;
    logic [IDB:0]   outstanding;
    logic           err_unexpected;

    internal_bus_master #(.IDBITS(IDB), .MAX_OUTSTANDING(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_rw(cmd_rw), .cmd_id(cmd_id),
        .mvalid(mvalid), .mready(mready), .mid(mid), .maddr(maddr),
        .mdata(mdata), .mrw(mrw),
        .svalid(svalid), .sready(sready), .sid(sid), .sresp(sresp),
        .sdata(sdata), .srw(srw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_rw(rsp_rw),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IDB-1:0] id;
        logic [31:0]    addr;
        logic [511:0]   data;
        logic           rw;
    } req_t;

    typedef struct {
        logic [IDB-1:0] id;
        logic [1:0]     resp;
        logic [511:0]   data;
        logic           rw;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t mon_req;
    rsp_t mon_rsp;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/extra expected handshake", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: handshakes visible at the falling edge complete on the next rising edge.
    always @(negedge clock) begin
        if (!reset && mvalid && mready) begin
            if (req_q.size() == 0) begin
                fail_now("req_extra");
            end else begin
                mon_req = req_q.pop_front();
                check("mid", mid, mon_req.id);
                check("maddr", maddr, mon_req.addr);
                check("mdata", mdata, mon_req.data);
                check("mrw", mrw, mon_req.rw);
            end
        end
        if (!reset && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                fail_now("rsp_extra");
            end else begin
                mon_rsp = rsp_q.pop_front();
                check("rsp_id", rsp_id, mon_rsp.id);
                check("rsp_resp", rsp_resp, mon_rsp.resp);
                check("rsp_data", rsp_data, mon_rsp.data);
                check("rsp_rw", rsp_rw, mon_rsp.rw);
            end
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input logic rw, input logic [511:0] data,
                            input logic [IDB-1:0] exp_id);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_rw    = rw;
        cmd_data  = data;
        while (!cmd_ready && t < 50) begin
            tick();
            t++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        check("cmd_id", cmd_id, exp_id);
        req_q.push_back('{exp_id, addr, data, rw});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [IDB-1:0] id, input logic [1:0] resp,
                            input logic [511:0] data, input logic rw);
        int t = 0;
        svalid = 1'b1;
        sid    = id;
        sresp  = resp;
        sdata  = data;
        srw    = rw;
        while (!sready && t < 50) begin
            tick();
            t++;
        end
        if (!sready) begin
            fail_now("rsp_accept");
            svalid = 1'b0;
            return;
        end
        rsp_q.push_back('{id, resp, data, rw});
        tick();
        svalid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        svalid    = 1'b0;
        tick();
        tick();
        check("rst_mvalid", mvalid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_cmd_id", cmd_id, 0);
        req_q.delete();
        rsp_q.delete();
        reset     = 1'b0;
        mready    = 1'b1;
        rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst0_mvalid", mvalid, 0);
        check("rst0_outstanding", outstanding, 0);
        reset = 1'b0;
        tick();

        // single read with one-cycle-late mready
        mready = 1'b0;
        send_cmd(32'h0000_1000, 1'b1, 512'h11, 4'd0);
        check("t1_mvalid_up", mvalid, 1);
        check("t1_outstanding", outstanding, 1);
        mready = 1'b1;
        tick();
        check("t1_mvalid_down", mvalid, 0);
        send_rsp(4'd0, 2'b00, 512'hABCD, 1'b1);
        check("t1_rsp_valid", rsp_valid, 1);
        tick();
        check("t1_outstanding_end", outstanding, 0);
        check("t1_rsp_drop", rsp_valid, 0);

        // fill to the outstanding limit
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_cmd(32'h2000 + 32'(k), 1'b0, 512'(k + 100), IDB'(k));
        end
        tick();
        check("t2_outstanding_full", outstanding, 4);
        check("t2_cmd_ready_full", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h3000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_blocked", cmd_ready, 0);
        end
        send_rsp(4'd2, 2'b00, 512'h22, 1'b0);
        check("t2_outstanding_3", outstanding, 3);
        check("t2_cmd_ready_open", cmd_ready, 1);
        send_cmd(32'h3000, 1'b1, 512'h0, 4'd4);
        tick();
        tick();

        // ID wrap blocked by a still-in-flight ID 0
        do_reset();
        send_cmd(32'h4000, 1'b1, 512'h0, 4'd0);
        for (int k = 1; k < 16; k++) begin
            send_cmd(32'h4000 + 32'(k), 1'b0, 512'(k), IDB'(k));
            send_rsp(IDB'(k), 2'b00, 512'(k * 3), 1'b0);
        end
        tick();
        check("t3_outstanding", outstanding, 1);
        check("t3_next_id", cmd_id, 0);
        check("t3_busy_block", cmd_ready, 0);
        send_rsp(4'd0, 2'b10, 512'h5A5A, 1'b1);
        check("t3_unblock", cmd_ready, 1);
        check("t3_outstanding_0", outstanding, 0);

        // response backpressure and back-to-back delivery
        do_reset();
        send_cmd(32'h5000, 1'b1, 512'h0, 4'd0);
        send_cmd(32'h5004, 1'b1, 512'h0, 4'd1);
        tick();
        rsp_ready = 1'b0;
        send_rsp(4'd0, 2'b00, 512'hAAAA, 1'b1);
        check("t4_sready_low", sready, 0);
        svalid = 1'b1;
        sid    = 4'd1;
        sresp  = 2'b01;
        sdata  = 512'hBBBB;
        srw    = 1'b1;
        rsp_q.push_back('{4'd1, 2'b01, 512'hBBBB, 1'b1});
        tick();
        check("t4_sready_held", sready, 0);
        check("t4_rsp_hold", rsp_id, 0);
        rsp_ready = 1'b1;
        tick();
        svalid = 1'b0;
        check("t4_b2b_valid", rsp_valid, 1);
        check("t4_b2b_id", rsp_id, 1);
        tick();
        check("t4_drained", rsp_valid, 0);
        check("t4_outstanding", outstanding, 0);

        // unexpected response ID
        do_reset();
        send_rsp(4'd7, 2'b01, 512'h77, 1'b0);
        check("t5_err", err_unexpected, 1);
        check("t5_fwd_id", rsp_id, 7);
        check("t5_outstanding", outstanding, 0);
        tick();
        tick();
        tick();
        check("t5_err_sticky", err_unexpected, 1);

        // async reset while a request is being issued
        do_reset();
        send_cmd(32'h6000, 1'b1, 512'h0, 4'd0);
        send_cmd(32'h6004, 1'b1, 512'h0, 4'd1);
        tick();
        rsp_ready = 1'b0;
        send_rsp(4'd0, 2'b00, 512'h60, 1'b1);
        mready = 1'b0;
        send_cmd(32'h6008, 1'b0, 512'h0, 4'd2);
        check("t6_outstanding_2", outstanding, 2);
        check("t6_mvalid_issue", mvalid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_mvalid", mvalid, 0);
        check("t6_async_rsp_valid", rsp_valid, 0);
        check("t6_async_outstanding", outstanding, 0);
        req_q.delete();
        rsp_q.delete();
        tick();
        reset     = 1'b0;
        mready    = 1'b1;
        rsp_ready = 1'b1;
        check("t6_err_clear", err_unexpected, 0);
        send_rsp(4'd0, 2'b00, 512'h61, 1'b1);
        check("t6_err_abandoned", err_unexpected, 1);
        check("t6_outstanding_end", outstanding, 0);

        tick();
        tick();
        tick();
        check("req_q_empty", req_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
